// File: rtl/ram_mover_pkg.sv
// ram_mover_pkg: shared definitions for the RAM block mover.
//   - MODE_COPY / MODE_FILL request mode encodings
//   - mover_state_e: controller state encoding
//   - depth_of(): RAM depth in words for a given index width
package ram_mover_pkg;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StStream,
    StDrain,
    StFill,
    StDone
  } mover_state_e;

  function automatic int unsigned depth_of(input int unsigned index_bits);
    return 32'd1 << index_bits;
  endfunction

endpackage

// File: rtl/mover_index_counter.sv
// mover_index_counter: loadable up/down word-index counter with a terminal flag.
// Ports:
//   i_clock        clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_load         load start index, word count and direction
//   i_start_index  first index of the run
//   i_length       number of words in the run (1..DEPTH when used)
//   i_down         1 = decrement per step, 0 = increment
//   i_step         advance to the next word
//   o_index        current word index
//   o_last         current word is the final word of the run
module mover_index_counter #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [INDEX_BITS-1:0] i_start_index,
  input  logic [INDEX_BITS:0]   i_length,
  input  logic                  i_down,
  input  logic                  i_step,
  output logic [INDEX_BITS-1:0] o_index,
  output logic                  o_last
);

  localparam logic [INDEX_BITS-1:0] IndexOne = {{(INDEX_BITS-1){1'b0}}, 1'b1};
  localparam logic [INDEX_BITS:0]   CountOne = {{INDEX_BITS{1'b0}}, 1'b1};

  logic [INDEX_BITS-1:0] r_index;
  logic [INDEX_BITS:0]   r_remaining;
  logic                  r_down;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_index     <= '0;
      r_remaining <= '0;
      r_down      <= 1'b0;
    end else if (i_load) begin
      r_index     <= i_start_index;
      r_remaining <= i_length - CountOne;
      r_down      <= i_down;
    end else if (i_step && !o_last) begin
      // Holding on the final word keeps the index inside 0..DEPTH-1.
      r_index     <= r_down ? (r_index - IndexOne) : (r_index + IndexOne);
      r_remaining <= r_remaining - CountOne;
    end
  end

  assign o_index = r_index;
  assign o_last  = (r_remaining == '0);

endmodule

// File: rtl/ram_block_mover.sv
// ram_block_mover: copies LEN words src->dst or fills LEN words at dst with a
// constant, driving one dual-port RAM (port 0 read-only, port 1 write-only).
// Ports:
//   i_clock / i_reset       clock (rising edge) / async active-low reset
//   i_start, i_mode         request pulse (sampled in idle), 0 = copy, 1 = fill
//   i_src_index/i_dst_index first source / destination word
//   i_length                word count 0..DEPTH
//   i_fill_data             fill value, captured at accept
//   o_busy, o_done, o_error status; error is valid with done and held until next accept
//   o_ram_we0/address0/data_in0, i_ram_data_out0   RAM port 0 (read, 1-cycle latency)
//   o_ram_we1/address1/data_in1                    RAM port 1 (write)
module ram_block_mover
  import ram_mover_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned INDEX_BITS    = 6
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_mode,
  input  logic [INDEX_BITS-1:0]    i_src_index,
  input  logic [INDEX_BITS-1:0]    i_dst_index,
  input  logic [INDEX_BITS:0]      i_length,
  input  logic [DATA_WIDTH-1:0]    i_fill_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic                     o_ram_we0,
  output logic [ADDRESS_WIDTH-1:0] o_ram_address0,
  output logic [DATA_WIDTH-1:0]    o_ram_data_in0,
  input  logic [DATA_WIDTH-1:0]    i_ram_data_out0,
  output logic                     o_ram_we1,
  output logic [ADDRESS_WIDTH-1:0] o_ram_address1,
  output logic [DATA_WIDTH-1:0]    o_ram_data_in1
);

  localparam logic [INDEX_BITS+1:0] DepthW   = (INDEX_BITS+2)'(depth_of(INDEX_BITS));
  localparam logic [INDEX_BITS-1:0] IndexOne = {{(INDEX_BITS-1){1'b0}}, 1'b1};

  mover_state_e          r_state;
  mover_state_e          w_state_next;
  logic                  r_mode;
  logic [DATA_WIDTH-1:0] r_fill_data;
  logic                  r_error;

  logic [INDEX_BITS+1:0] w_src_end;
  logic [INDEX_BITS+1:0] w_dst_end;
  logic                  w_is_copy;
  logic                  w_range_error;
  logic                  w_trivial;
  logic                  w_descend;
  logic                  w_accept;
  logic [INDEX_BITS-1:0] w_src_first;
  logic [INDEX_BITS-1:0] w_dst_first;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic [INDEX_BITS-1:0] w_rd_index;
  logic [INDEX_BITS-1:0] w_wr_index;
  logic                  w_rd_last;
  logic                  w_wr_last;

  // Request decode, evaluated on the live inputs in the accept cycle.
  always_comb begin
    w_src_end     = {2'b00, i_src_index} + {1'b0, i_length};
    w_dst_end     = {2'b00, i_dst_index} + {1'b0, i_length};
    w_is_copy     = (i_mode == MODE_COPY);
    w_range_error = (w_dst_end > DepthW) || (w_is_copy && (w_src_end > DepthW));
    w_trivial     = (i_length == '0) || (w_is_copy && (i_src_index == i_dst_index));
    // Destination overlapping the tail of the source must be copied top-down.
    w_descend     = w_is_copy && (i_src_index < i_dst_index) &&
                    ({2'b00, i_dst_index} < w_src_end);
    // Truncation is safe: end <= DEPTH, so end-1 fits in INDEX_BITS.
    w_src_first   = w_descend ? (w_src_end[INDEX_BITS-1:0] - IndexOne) : i_src_index;
    w_dst_first   = w_descend ? (w_dst_end[INDEX_BITS-1:0] - IndexOne) : i_dst_index;
    w_accept      = (r_state == StIdle) && i_start;
  end

  mover_index_counter #(
    .INDEX_BITS(INDEX_BITS)
  ) u_read_counter (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (w_accept),
    .i_start_index(w_src_first),
    .i_length     (i_length),
    .i_down       (w_descend),
    .i_step       (w_rd_en),
    .o_index      (w_rd_index),
    .o_last       (w_rd_last)
  );

  mover_index_counter #(
    .INDEX_BITS(INDEX_BITS)
  ) u_write_counter (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (w_accept),
    .i_start_index(w_dst_first),
    .i_length     (i_length),
    .i_down       (w_descend),
    .i_step       (w_wr_en),
    .o_index      (w_wr_index),
    .o_last       (w_wr_last)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_mode      <= MODE_COPY;
      r_fill_data <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mode      <= i_mode;
        r_fill_data <= i_fill_data;
        r_error     <= w_range_error;
      end
    end
  end

  // Copy pipeline: PRIME issues the first read, STREAM overlaps read k+1 with
  // write k, DRAIN writes the last word returned by the RAM.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_range_error || w_trivial) begin
            w_state_next = StDone;
          end else if (i_mode == MODE_FILL) begin
            w_state_next = StFill;
          end else begin
            w_state_next = StPrime;
          end
        end
      end
      StPrime: begin
        w_rd_en      = 1'b1;
        w_state_next = w_rd_last ? StDrain : StStream;
      end
      StStream: begin
        w_rd_en = 1'b1;
        w_wr_en = 1'b1;
        if (w_rd_last) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        w_wr_en      = 1'b1;
        w_state_next = StDone;
      end
      StFill: begin
        w_wr_en = 1'b1;
        if (w_wr_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign o_busy         = (r_state != StIdle) && (r_state != StDone);
  assign o_done         = (r_state == StDone);
  assign o_error        = r_error;
  assign o_ram_we0      = 1'b0;
  assign o_ram_data_in0 = '0;
  assign o_ram_address0 = w_rd_en ? {{(ADDRESS_WIDTH-INDEX_BITS){1'b0}}, w_rd_index} : '0;
  assign o_ram_we1      = w_wr_en;
  assign o_ram_address1 = w_wr_en ? {{(ADDRESS_WIDTH-INDEX_BITS){1'b0}}, w_wr_index} : '0;
  assign o_ram_data_in1 = !w_wr_en ? '0 :
                          (r_mode == MODE_FILL) ? r_fill_data : i_ram_data_out0;

endmodule

// File: tb/tb_ram_block_mover.sv
// tb_ram_block_mover: directed tests for ram_block_mover against a behavioural
// dual-port RAM. Expected completion records are queued at issue time and
// checked by a monitor on every done pulse; memory is compared to a model.
module tb_ram_block_mover;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned IB    = 6;
  localparam int unsigned DEPTH = 64;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic [IB-1:0] src   = '0;
  logic [IB-1:0] dst   = '0;
  logic [IB:0]   len   = '0;
  logic [DW-1:0] fill  = '0;

  logic          busy, done, error, we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] din0, din1, dout0;

  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] model [DEPTH];
  logic          tb_we    = 1'b0;
  logic [IB-1:0] tb_addr  = '0;
  logic [DW-1:0] tb_wdata = '0;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  typedef struct {
    logic err;
    int   done_cyc;
    int   we_cnt;
    int   first_wa;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_block_mover #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .INDEX_BITS   (IB)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_start        (start),
    .i_mode         (mode),
    .i_src_index    (src),
    .i_dst_index    (dst),
    .i_length       (len),
    .i_fill_data    (fill),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_ram_we0      (we0),
    .o_ram_address0 (a0),
    .o_ram_data_in0 (din0),
    .i_ram_data_out0(dout0),
    .o_ram_we1      (we1),
    .o_ram_address1 (a1),
    .o_ram_data_in1 (din1)
  );

  // Dual-port RAM: registered read on port 0, write on port 1 (bench loads via tb_we).
  always @(posedge clk) begin
    dout0 <= mem[a0[IB-1:0]];
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (we1) mem[a1[IB-1:0]] <= din1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: cycles counted from the accept edge (cycle 0) to the done pulse.
  int neg_cnt = 0, acc_at = 0, we_cnt = 0, first_wa = -1;
  always @(negedge clk) begin
    exp_t e;
    neg_cnt++;
    if (rst_n && start && !busy && !done) begin
      acc_at   = neg_cnt;
      we_cnt   = 0;
      first_wa = -1;
    end else if (we1) begin
      if (we_cnt == 0) first_wa = int'(a1[IB-1:0]);
      we_cnt++;
    end
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: got done at cycle %0d want none", neg_cnt - acc_at);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 64'(neg_cnt - acc_at), 64'(e.done_cyc));
        chk("error_at_done", 64'(error), 64'(e.err));
        chk("we1_cycles", 64'(we_cnt), 64'(e.we_cnt));
        if (e.we_cnt > 0) chk("first_write_addr", 64'(first_wa), 64'(e.first_wa));
      end
    end
  end

  task automatic expect_done(input logic e, input int c, input int w, input int f);
    exp_t x;
    x.err = e; x.done_cyc = c; x.we_cnt = w; x.first_wa = f;
    sb.push_back(x);
  endtask

  task automatic issue(input logic m, input int s, input int d, input int l,
                       input logic [DW-1:0] f);
    @(posedge clk); #1;
    mode = m; src = IB'(s); dst = IB'(d); len = (IB+1)'(l); fill = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_done_in_time"}, 64'(k < 200), 64'd1);
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int first = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem[i] !== model[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s: %0d words differ, first mem[%0d] got %0h want %0h",
               name, bad, first, mem[first], model[first]);
    end
  endtask

  initial begin
    // Load mem[i] = i while the mover is held in reset.
    for (int i = 0; i < int'(DEPTH); i++) begin
      @(posedge clk); #1;
      tb_we = 1'b1; tb_addr = IB'(i); tb_wdata = DW'(i); model[i] = DW'(i);
    end
    @(posedge clk); #1;
    tb_we = 1'b0;

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_we0", 64'(we0), 64'd0);
    chk("rst_we1", 64'(we1), 64'd0);
    chk("rst_addr0", 64'(a0), 64'd0);
    chk("rst_addr1", 64'(a1), 64'd0);
    chk("rst_din0", 64'(din0), 64'd0);
    chk("rst_din1", 64'(din1), 64'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    check_mem("mem_init");

    // Plain ascending copy.
    expect_done(1'b0, 10, 8, 32);
    issue(1'b0, 0, 32, 8, '0);
    for (int i = 0; i < 8; i++) model[32+i] = DW'(i);
    wait_done("copy_0_32");
    @(posedge clk); #1;
    check_mem("mem_copy_0_32");

    // Overlapping copy, must run top-down: first read is word 13.
    expect_done(1'b0, 12, 10, 15);
    issue(1'b0, 4, 6, 10, '0);
    chk("overlap_first_read_addr", 64'(a0), 64'd13);
    chk("overlap_we0", 64'(we0), 64'd0);
    chk("overlap_din0", 64'(din0), 64'd0);
    for (int i = 0; i < 10; i++) model[6+i] = DW'(4 + i);
    wait_done("copy_overlap");
    @(posedge clk); #1;
    check_mem("mem_copy_overlap");

    // Fill ending exactly at the top of the RAM.
    expect_done(1'b0, 5, 4, 60);
    issue(1'b1, 0, 60, 4, 32'hDEADBEEF);
    for (int i = 60; i < 64; i++) model[i] = 32'hDEADBEEF;
    wait_done("fill_top");
    @(posedge clk); #1;
    check_mem("mem_fill_top");

    // Range violation: 60+5 > 64.
    expect_done(1'b1, 1, 0, 0);
    issue(1'b0, 0, 60, 5, '0);
    wait_done("range_error");
    repeat (3) @(posedge clk); #1;
    chk("error_held_in_idle", 64'(error), 64'd1);
    check_mem("mem_range_error");

    // Zero length clears the held error.
    expect_done(1'b0, 1, 0, 0);
    issue(1'b0, 1, 2, 0, '0);
    wait_done("len_zero");
    @(posedge clk); #1;
    chk("error_cleared", 64'(error), 64'd0);

    // src == dst is a no-op.
    expect_done(1'b0, 1, 0, 0);
    issue(1'b0, 9, 9, 4, '0);
    wait_done("src_eq_dst");

    // Single word from the last index: PRIME goes straight to DRAIN.
    expect_done(1'b0, 3, 1, 50);
    issue(1'b0, 63, 50, 1, '0);
    model[50] = 32'hDEADBEEF;
    wait_done("len_one");
    @(posedge clk); #1;
    check_mem("mem_len_one");

    // Reset during cycle 4 of a 16-word copy: words 0 and 1 already written.
    issue(1'b0, 0, 40, 16, '0);
    repeat (3) @(posedge clk); #1;
    chk("we1_before_reset", 64'(we1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("we1_on_reset", 64'(we1), 64'd0);
    chk("busy_on_reset", 64'(busy), 64'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    model[40] = 32'd0;
    model[41] = 32'd1;
    repeat (3) @(posedge clk); #1;
    chk("done_after_reset", 64'(done), 64'd0);
    check_mem("mem_reset_abort");

    // start re-pulsed while busy is ignored.
    expect_done(1'b0, 7, 6, 20);
    issue(1'b1, 0, 20, 6, 32'hA5A50F0F);
    @(posedge clk); #1;
    mode = 1'b1; dst = '0; len = (IB+1)'(2); fill = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 20; i < 26; i++) model[i] = 32'hA5A50F0F;
    wait_done("fill_repulse");
    repeat (10) @(posedge clk); #1;
    check_mem("mem_fill_repulse");

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("done_pulse_count", 64'(n_done), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
